// File: rtl/order_book_pkg.sv
// Shared types and field widths for the order-book arbiter slice.
package order_book_pkg;

  typedef enum logic [1:0] {
    ORDER_ADD     = 2'd0,
    ORDER_CANCEL  = 2'd1,
    ORDER_EXECUTE = 2'd2
  } order_t;

  localparam logic [1:0] ORDER_TYPE_ILLEGAL = 2'd3;

  localparam int QTY_W   = 16;
  localparam int PRICE_W = 32;
  localparam int OID_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/order_book_arbiter_if.sv
// Requester-side and book-side order bus of the arbiter.
// slave = arbiter view, master = requesters/book view.
interface order_book_arbiter_if
  import order_book_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_STOCKS = 4
);
  localparam int SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic [NUM_REQ-1:0]         i_req_valid;
  logic [NUM_REQ-1:0]         o_req_ready;
  logic [NUM_REQ*SID_W-1:0]   i_req_stock_id;
  logic [NUM_REQ*2-1:0]       i_req_order_type;
  logic [NUM_REQ*QTY_W-1:0]   i_req_quantity;
  logic [NUM_REQ*PRICE_W-1:0] i_req_price;
  logic [NUM_REQ*OID_W-1:0]   i_req_order_id;

  logic [SID_W-1:0]           o_stock_id;
  logic [1:0]                 o_order_type;
  logic [QTY_W-1:0]           o_quantity;
  logic [PRICE_W-1:0]         o_price;
  logic [OID_W-1:0]           o_order_id;
  logic                       o_order_valid;
  logic                       i_book_is_busy;

  modport slave (
    input  i_req_valid, i_req_stock_id, i_req_order_type, i_req_quantity,
           i_req_price, i_req_order_id, i_book_is_busy,
    output o_req_ready, o_stock_id, o_order_type, o_quantity, o_price,
           o_order_id, o_order_valid
  );

  modport master (
    output i_req_valid, i_req_stock_id, i_req_order_type, i_req_quantity,
           i_req_price, i_req_order_id, i_book_is_busy,
    input  o_req_ready, o_stock_id, o_order_type, o_quantity, o_price,
           o_order_id, o_order_valid
  );

endinterface

// File: rtl/order_book_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request
// at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  // priority scan starting from the pointer
  always_comb begin
    logic found_s;
    logic hit_s;
    int   idx_s;
    o_gnt   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s        = (int'(i_ptr) + i) % N;
      hit_s        = !found_s && i_req[idx_s];
      o_gnt[idx_s] = hit_s;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/order_book_arbiter.sv
// Round-robin order arbiter in front of the order-book write port.
// Optional per-requester issue counters: define ARB_GRANT_STATS_EN.
module order_book_arbiter
  import order_book_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int NUM_STOCKS  = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16,
  localparam int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  order_book_arbiter_if.slave  bus,
  output logic [GID_W-1:0]     o_grant_id,
  output logic                 o_arb_busy,
  output logic                 o_timeout_err,
  output logic [CNT_WIDTH-1:0] o_drop_count
`ifdef ARB_GRANT_STATS_EN
  ,output logic [NUM_REQ*CNT_WIDTH-1:0] o_grant_count
`endif
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  arb_state_t          state_r;
  logic [GID_W-1:0]    rr_ptr_r;
  logic [TO_W-1:0]     ack_cnt_r;
  logic [SID_W-1:0]    stock_id_r;
  logic [1:0]          order_type_r;
  logic [QTY_W-1:0]    quantity_r;
  logic [PRICE_W-1:0]  price_r;
  logic [OID_W-1:0]    order_id_r;
  logic                order_valid_r;
  logic [GID_W-1:0]    grant_id_r;
  logic                timeout_err_r;
  logic [CNT_WIDTH-1:0] drop_count_r;
`ifdef ARB_GRANT_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt_r;
`endif

  logic [NUM_REQ-1:0]  req_s;
  logic [NUM_REQ-1:0]  gnt_s;
  logic [GID_W-1:0]    gidx_s;
  logic                accept_s;
  logic [SID_W-1:0]    sel_sid_s;
  logic [1:0]          sel_type_s;
  logic [QTY_W-1:0]    sel_qty_s;
  logic [PRICE_W-1:0]  sel_price_s;
  logic [OID_W-1:0]    sel_oid_s;
  logic [GID_W-1:0]    rr_next_s;

  // requests are only eligible while idle and the book is quiet
  assign req_s = bus.i_req_valid &
                 {NUM_REQ{(state_r == ST_IDLE) && !bus.i_book_is_busy && !i_reset}};

  rr_arbiter #(.N(NUM_REQ), .PW(GID_W)) u_rr (
    .i_req (req_s),
    .i_ptr (rr_ptr_r),
    .o_gnt (gnt_s)
  );

  assign bus.o_req_ready = gnt_s;
  assign accept_s        = |gnt_s;

  // one-hot grant to index, then field mux for the winner
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s = gidx_s | (gnt_s[i] ? GID_W'(i) : '0);
    end
    sel_sid_s   = bus.i_req_stock_id[int'(gidx_s)*SID_W +: SID_W];
    sel_type_s  = bus.i_req_order_type[int'(gidx_s)*2 +: 2];
    sel_qty_s   = bus.i_req_quantity[int'(gidx_s)*QTY_W +: QTY_W];
    sel_price_s = bus.i_req_price[int'(gidx_s)*PRICE_W +: PRICE_W];
    sel_oid_s   = bus.i_req_order_id[int'(gidx_s)*OID_W +: OID_W];
    rr_next_s   = (int'(gidx_s) == NUM_REQ - 1) ? '0 : gidx_s + GID_W'(1);
  end

  // arbiter FSM, order registers and counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      ack_cnt_r     <= '0;
      stock_id_r    <= '0;
      order_type_r  <= 2'd0;
      quantity_r    <= '0;
      price_r       <= '0;
      order_id_r    <= '0;
      order_valid_r <= 1'b0;
      grant_id_r    <= '0;
      timeout_err_r <= 1'b0;
      drop_count_r  <= '0;
`ifdef ARB_GRANT_STATS_EN
      grant_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          order_valid_r <= 1'b0;
          if (accept_s) begin
            stock_id_r   <= sel_sid_s;
            order_type_r <= sel_type_s;
            quantity_r   <= sel_qty_s;
            price_r      <= sel_price_s;
            order_id_r   <= sel_oid_s;
            grant_id_r   <= gidx_s;
            rr_ptr_r     <= rr_next_s;
            if (sel_type_s == ORDER_TYPE_ILLEGAL) begin
              drop_count_r <= sat_inc(drop_count_r);
            end else begin
              state_r       <= ST_ISSUE;
              order_valid_r <= 1'b1;
`ifdef ARB_GRANT_STATS_EN
              grant_cnt_r[int'(gidx_s)*CNT_WIDTH +: CNT_WIDTH] <=
                sat_inc(grant_cnt_r[int'(gidx_s)*CNT_WIDTH +: CNT_WIDTH]);
`endif
            end
          end
        end
        ST_ISSUE: begin
          order_valid_r <= 1'b0;
          ack_cnt_r     <= '0;
          state_r       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          order_valid_r <= 1'b0;
          if (bus.i_book_is_busy) begin
            state_r <= ST_WAIT_DONE;
          end else if (ack_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            ack_cnt_r <= ack_cnt_r + TO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          order_valid_r <= 1'b0;
          if (!bus.i_book_is_busy) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          order_valid_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_stock_id    = stock_id_r;
  assign bus.o_order_type  = order_type_r;
  assign bus.o_quantity    = quantity_r;
  assign bus.o_price       = price_r;
  assign bus.o_order_id    = order_id_r;
  assign bus.o_order_valid = order_valid_r;
  assign o_grant_id        = grant_id_r;
  assign o_arb_busy        = (state_r != ST_IDLE);
  assign o_timeout_err     = timeout_err_r;
  assign o_drop_count      = drop_count_r;
`ifdef ARB_GRANT_STATS_EN
  assign o_grant_count     = grant_cnt_r;
`endif

endmodule
